// File: rtl/detector_direcao_contagem_pkg.sv
// -----------------------------------------------------------------------------
// detector_pkg
// Shared types for the counter-direction observer: FSM states, step classes,
// the saturation limit of the locked-step counter and its increment helper.
// -----------------------------------------------------------------------------
package detector_pkg;

   typedef enum logic [1:0] {
      VAZIO   = 2'd0,
      BUSCA   = 2'd1,
      TRAVADO = 2'd2,
      ERRO    = 2'd3
   } estado_e;

   typedef enum logic [1:0] {
      SUBIR  = 2'd0,
      DESCER = 2'd1,
      PARADO = 2'd2,
      SALTO  = 2'd3
   } passo_e;

   localparam logic [7:0] PASSOS_MAX = 8'd255;

   // Increment that sticks at PASSOS_MAX instead of wrapping.
   function automatic logic [7:0] inc_sat(input logic [7:0] v);
      return (v == PASSOS_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/detector_direcao_contagem_if.sv
// -----------------------------------------------------------------------------
// detector_direcao_contagem_if
// Bus between the count source (master) and the direction observer (slave).
//   amostra        : observed count value
//   amostra_valid  : amostra is sampled on this rising edge
//   limpar         : synchronous clear back to the empty state
//   direcao        : recovered direction (1 = up), valid while travado
//   travado        : direction locked
//   reversao       : one-cycle pulse on a reversal of a locked direction
//   erro           : sticky jump-while-locked flag
//   passos         : same-direction steps since lock, saturating
// -----------------------------------------------------------------------------
interface detector_direcao_contagem_if #(
   parameter int NBITS_COUNT = 4
);
   logic [NBITS_COUNT-1:0] amostra;
   logic                   amostra_valid;
   logic                   limpar;
   logic                   direcao;
   logic                   travado;
   logic                   reversao;
   logic                   erro;
   logic [7:0]             passos;

   modport master (
      output amostra, amostra_valid, limpar,
      input  direcao, travado, reversao, erro, passos
   );

   modport slave (
      input  amostra, amostra_valid, limpar,
      output direcao, travado, reversao, erro, passos
   );
endinterface

// File: rtl/detector_direcao_contagem_classificador.sv
// -----------------------------------------------------------------------------
// classificador_passo
// Combinational step classifier. The difference amostra - anterior is taken
// modulo 2^NBITS_COUNT so that counter wrap-around reads as a unit step.
//   anterior_i : previous accepted sample
//   amostra_i  : current sample
//   classe_o   : SUBIR (+1), DESCER (-1), PARADO (0) or SALTO (anything else)
// -----------------------------------------------------------------------------
module classificador_passo
   import detector_pkg::*;
#(
   parameter int NBITS_COUNT = 4
) (
   input  logic [NBITS_COUNT-1:0] anterior_i,
   input  logic [NBITS_COUNT-1:0] amostra_i,
   output passo_e                 classe_o
);

   logic [NBITS_COUNT-1:0] delta;

   assign delta = amostra_i - anterior_i;

   always_comb begin
      if (delta == NBITS_COUNT'(1))
         classe_o = SUBIR;
      else if (delta == {NBITS_COUNT{1'b1}})
         classe_o = DESCER;
      else if (delta == '0)
         classe_o = PARADO;
      else
         classe_o = SALTO;
   end

endmodule

// File: rtl/detector_direcao_contagem.sv
// -----------------------------------------------------------------------------
// detector_direcao_contagem
// Observer for an up/down counter output bus. Each accepted sample is compared
// with the previous one; CONFIRM consecutive same-direction unit steps lock
// the direction, after which same-direction steps are counted. Opposite steps
// while locked pulse reversao; a jump while locked latches erro until limpar.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   bus    : slave side of detector_direcao_contagem_if (sample in, status out)
// -----------------------------------------------------------------------------
module detector_direcao_contagem
   import detector_pkg::*;
#(
   parameter int NBITS_COUNT = 4,
   parameter int CONFIRM     = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   detector_direcao_contagem_if.slave    bus
);

   localparam logic [3:0] CONFIRM_W = 4'(CONFIRM);

   estado_e                estado_q, estado_d;
   logic [NBITS_COUNT-1:0] anterior_q, anterior_d;
   logic                   cand_q, cand_d;
   logic [3:0]             run_q, run_d;
   logic                   direcao_q, direcao_d;
   logic                   travado_q, travado_d;
   logic                   reversao_q, reversao_d;
   logic                   erro_q, erro_d;
   logic [7:0]             passos_q, passos_d;

   passo_e                 classe;
   logic                   sobe;
   logic [3:0]             run_nx;

   classificador_passo #(
      .NBITS_COUNT (NBITS_COUNT)
   ) u_classificador (
      .anterior_i (anterior_q),
      .amostra_i  (bus.amostra),
      .classe_o   (classe)
   );

   // Only meaningful for SUBIR/DESCER.
   assign sobe = (classe == SUBIR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q   <= VAZIO;
         anterior_q <= '0;
         cand_q     <= 1'b0;
         run_q      <= '0;
         direcao_q  <= 1'b0;
         travado_q  <= 1'b0;
         reversao_q <= 1'b0;
         erro_q     <= 1'b0;
         passos_q   <= '0;
      end else begin
         estado_q   <= estado_d;
         anterior_q <= anterior_d;
         cand_q     <= cand_d;
         run_q      <= run_d;
         direcao_q  <= direcao_d;
         travado_q  <= travado_d;
         reversao_q <= reversao_d;
         erro_q     <= erro_d;
         passos_q   <= passos_d;
      end
   end

   always_comb begin
      estado_d   = estado_q;
      anterior_d = anterior_q;
      cand_d     = cand_q;
      run_d      = run_q;
      direcao_d  = direcao_q;
      travado_d  = travado_q;
      reversao_d = 1'b0;
      erro_d     = erro_q;
      passos_d   = passos_q;
      run_nx     = run_q;

      // limpar wins over a simultaneous sample, which is dropped entirely
      // (anterior is not updated either).
      if (bus.limpar) begin
         estado_d  = VAZIO;
         erro_d    = 1'b0;
         travado_d = 1'b0;
         passos_d  = '0;
      end else if (bus.amostra_valid) begin
         anterior_d = bus.amostra;
         unique case (estado_q)
            VAZIO: begin
               estado_d = BUSCA;
               run_d    = '0;
            end

            BUSCA: begin
               case (classe)
                  SUBIR, DESCER: begin
                     // run=0 means no candidate yet, so any step starts one.
                     if (run_q == '0 || cand_q != sobe) begin
                        cand_d = sobe;
                        run_nx = 4'd1;
                     end else begin
                        run_nx = run_q + 4'd1;
                     end
                     run_d = run_nx;
                     if (run_nx == CONFIRM_W) begin
                        estado_d  = TRAVADO;
                        direcao_d = cand_d;
                        travado_d = 1'b1;
                        passos_d  = '0;
                     end
                  end
                  SALTO:   run_d = '0;
                  default: ;
               endcase
            end

            TRAVADO: begin
               case (classe)
                  SUBIR, DESCER: begin
                     if (sobe == direcao_q) begin
                        passos_d = inc_sat(passos_q);
                     end else begin
                        reversao_d = 1'b1;
                        cand_d     = sobe;
                        run_d      = 4'd1;
                        // A single opposite step already satisfies CONFIRM=1,
                        // so the lock flips direction in place.
                        if (CONFIRM_W == 4'd1) begin
                           direcao_d = sobe;
                           passos_d  = '0;
                        end else begin
                           estado_d  = BUSCA;
                           travado_d = 1'b0;
                        end
                     end
                  end
                  SALTO: begin
                     estado_d  = ERRO;
                     erro_d    = 1'b1;
                     travado_d = 1'b0;
                  end
                  default: ;
               endcase
            end

            ERRO: ;
         endcase
      end
   end

   assign bus.direcao  = direcao_q;
   assign bus.travado  = travado_q;
   assign bus.reversao = reversao_q;
   assign bus.erro     = erro_q;
   assign bus.passos   = passos_q;

endmodule

// File: tb/tb_detector_direcao_contagem.sv
// -----------------------------------------------------------------------------
// tb_detector_direcao_contagem
// Directed scenarios followed by a randomized random-walk phase, all compared
// cycle by cycle against a behavioural model of the observer.
// -----------------------------------------------------------------------------
module tb_detector_direcao_contagem;

   localparam int NB      = 4;
   localparam int M       = 1 << NB;
   localparam int CONFIRM = 2;

   logic clk;
   logic reset;

   detector_direcao_contagem_if #(.NBITS_COUNT(NB)) bus ();

   detector_direcao_contagem #(
      .NBITS_COUNT (NB),
      .CONFIRM     (CONFIRM)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Behavioural model: tracks whether a previous sample exists, the streak
   // of agreeing unit steps, lock, error and the locked-step count.
   bit m_seen, m_locked, m_err, m_dir, m_rev, m_sdir;
   int m_prev, m_streak, m_passos;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_seen = 0; m_locked = 0; m_err = 0; m_dir = 0; m_rev = 0; m_sdir = 0;
      m_prev = 0; m_streak = 0; m_passos = 0;
   endtask

   task automatic model_edge(input int a, input bit v, input bit clr);
      int d;
      int step;  // +1 up, -1 down, 0 hold, 2 jump
      m_rev = 0;
      if (clr) begin
         m_seen = 0; m_locked = 0; m_err = 0; m_passos = 0;
         return;
      end
      if (!v) return;
      if (!m_seen) begin
         m_seen = 1; m_prev = a; m_streak = 0;
         return;
      end
      d = (a - m_prev + M) % M;
      m_prev = a;
      if (m_err) return;
      step = (d == 1) ? 1 : (d == M - 1) ? -1 : (d == 0) ? 0 : 2;
      if (m_locked) begin
         if (step == 2) begin
            m_locked = 0; m_err = 1;
         end else if (step != 0) begin
            if ((step > 0) == m_dir) begin
               if (m_passos < 255) m_passos++;
            end else begin
               m_rev = 1;
               if (CONFIRM == 1) begin
                  m_dir = ~m_dir; m_passos = 0;
               end else begin
                  m_locked = 0; m_streak = 1; m_sdir = (step > 0);
               end
            end
         end
      end else begin
         if (step == 2) m_streak = 0;
         else if (step != 0) begin
            if (m_streak > 0 && m_sdir == (step > 0)) m_streak++;
            else begin
               m_sdir = (step > 0); m_streak = 1;
            end
            if (m_streak >= CONFIRM) begin
               m_locked = 1; m_dir = m_sdir; m_passos = 0;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("direcao",  bus.direcao,  m_dir);
      chk("travado",  bus.travado,  m_locked);
      chk("reversao", bus.reversao, m_rev);
      chk("erro",     bus.erro,     m_err);
      chk("passos",   bus.passos,   m_passos);
   endtask

   // Called #1 after a rising edge: apply inputs, take the next edge, check.
   task automatic cycle(input int a, input bit v, input bit clr);
      bus.amostra       = NB'(a);
      bus.amostra_valid = v;
      bus.limpar        = clr;
      @(posedge clk);
      model_edge(a, v, clr);
      #1;
      check_all();
   endtask

   task automatic smp(input int a);
      cycle(a, 1'b1, 1'b0);
   endtask

   int cur;
   bit up;
   int r;

   initial begin
      bus.amostra = '0; bus.amostra_valid = 1'b0; bus.limpar = 1'b0;
      reset = 1'b0;
      model_reset();
      #3;
      check_all();
      #9 reset = 1'b1;
      @(posedge clk);
      model_edge(0, 0, 0);
      #1;
      check_all();

      // Plain lock upward
      smp(3); smp(4); smp(5);
      chk("lock_trav", bus.travado, 1);
      chk("lock_dir",  bus.direcao, 1);
      smp(6);
      chk("lock_passos", bus.passos, 1);

      // Lock through the wrap, then reverse and relock downward
      cycle(0, 0, 1);
      smp(14); smp(15); smp(0);
      chk("wrap_trav", bus.travado, 1);
      smp(1);
      chk("wrap_passos", bus.passos, 1);
      smp(1); smp(0);
      chk("rev_pulse", bus.reversao, 1);
      chk("rev_trav",  bus.travado, 0);
      smp(15);
      chk("relock_trav", bus.travado, 1);
      chk("relock_dir",  bus.direcao, 0);
      cycle(15, 0, 0);
      chk("rev_one_cycle", bus.reversao, 0);

      // Jump while locked, sticky error, limpar with a simultaneous sample
      cycle(0, 0, 1);
      smp(5); smp(6); smp(7); smp(10);
      chk("jump_erro", bus.erro, 1);
      chk("jump_trav", bus.travado, 0);
      smp(11); smp(12);
      chk("erro_sticky", bus.erro, 1);
      cycle(13, 1, 1);
      chk("limpar_erro", bus.erro, 0);
      smp(14); smp(15);
      chk("limpar_discard", bus.travado, 0);

      // Long hold, then saturation of passos
      cycle(0, 0, 1);
      smp(3); smp(4); smp(5);
      for (int i = 0; i < 300; i++) smp(5);
      chk("hold_passos", bus.passos, 0);
      chk("hold_trav",   bus.travado, 1);
      for (int i = 1; i <= 260; i++) smp((5 + i) % M);
      chk("sat_passos", bus.passos, 255);

      // Jump during search only restarts the streak
      cycle(0, 0, 1);
      smp(2); smp(3); smp(5); smp(6);
      chk("busca_jump_erro", bus.erro, 0);
      chk("busca_jump_trav", bus.travado, 0);
      smp(7);
      chk("busca_lock", bus.travado, 1);
      smp(8);

      // Asynchronous reset between edges
      bus.amostra_valid = 1'b0;
      #3 reset = 1'b0;
      #1;
      model_reset();
      chk("arst_trav",   bus.travado, 0);
      chk("arst_passos", bus.passos, 0);
      check_all();
      #2 reset = 1'b1;
      cycle(0, 0, 0);
      smp(9);
      chk("arst_first_busca", bus.travado, 0);
      smp(10); smp(11);
      chk("arst_relock", bus.travado, 1);

      // Randomized random walk with holds, jumps, reversals, gaps and clears
      cur = 11; up = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            cycle(cur, 1'b1, 1'b1);
         end else if (r < 20) begin
            cycle(cur, 1'b0, 1'b0);
         end else begin
            if (r < 27) up = ~up;
            if (r < 31) cur = $urandom_range(0, M - 1);
            else if (r >= 40) cur = up ? (cur + 1) % M : (cur + M - 1) % M;
            smp(cur);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/detector_direcao_contagem.md
# detector_direcao_contagem

Observer for the up/down counter output bus. Samples an `NBITS_COUNT`-bit count value and classifies each change between consecutive valid samples as an up step, a down step, a hold, or a jump. It recovers the counting direction once enough consecutive steps agree, and counts locked steps. It flags reversals and illegal jumps. It sits at the receiving end of a counter's `saida` bus, in the same clock domain.

## Interface
- `NBITS_COUNT`, 4: width of the observed count value.
- `CONFIRM`, 2: consecutive same-direction steps required to lock; legal range 1..15.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `amostra`  in  NBITS_COUNT: observed count value.
- `amostra_valid`  in  1: `amostra` is sampled on this cycle's rising edge.
- `limpar`  in  1: synchronous clear; returns the FSM to VAZIO and clears `erro`.
- `direcao`  out  1: recovered direction, 1 = up, 0 = down; meaningful only while `travado`=1.
- `travado`  out  1: direction locked.
- `reversao`  out  1: one-cycle pulse when a locked direction is broken by an opposite step.
- `erro`  out  1: sticky flag, set on a jump while locked.
- `passos`  out  8: same-direction steps seen since lock, saturating at 255.

## Operation
- Step class: `delta = amostra - anterior`, mod 2^NBITS_COUNT.
  - `delta` = 1: SUBIR.
  - `delta` = all ones: DESCER.
  - `delta` = 0: PARADO.
  - any other value: SALTO.
  - Wrap-around is legal: 15→0 is SUBIR and 0→15 is DESCER (for N=4).
- `anterior` loads `amostra` on every accepted sample, including in ERRO.
- Internal state: candidate direction `cand` (1 bit) and run counter `run` (4 bits).
- FSM states: VAZIO, BUSCA, TRAVADO, ERRO.
- VAZIO:
  - Valid sample: store it, go to BUSCA with `run`=0.
- BUSCA:
  - SUBIR or DESCER matching `cand`: `run`+1.
  - SUBIR or DESCER not matching `cand`, or `run`=0: `cand` takes the new direction and `run`=1.
  - When `run` reaches CONFIRM: go to TRAVADO, `direcao`=`cand`, `travado`=1, `passos`=0.
  - PARADO: no change.
  - SALTO: `run`=0 and no error.
- TRAVADO:
  - Same-direction step: `passos`+1, saturating at 255.
  - PARADO: no change.
  - Opposite step: go to BUSCA with `cand`=new direction and `run`=1; `travado`=0, `reversao` pulses, `passos` holds its value. With CONFIRM=1, the same step relocks instead: stay in TRAVADO, `direcao` flips, `passos`=0, `reversao` pulses.
  - SALTO: go to ERRO, `erro`=1, `travado`=0.
- ERRO:
  - Ignores step classes; leaves only on `limpar` or `reset`.
- `limpar`=1:
  - Go to VAZIO next edge; `erro`, `travado`, `reversao` and `passos` clear.
  - Takes priority over a simultaneous `amostra_valid`, and that sample is discarded.
- `amostra_valid`=0: state and all outputs hold, except `reversao`, which returns to 0.

## Timing
- All outputs are registered.
- Reset: `reset`=0 forces all of the following immediately, regardless of `clk`:
  - State VAZIO.
  - `direcao`=0, `travado`=0, `reversao`=0, `erro`=0, `passos`=0.
  - `anterior`=0, `cand`=0, `run`=0.
- Reset asserted mid-operation discards the lock and the history.
- Latency: the outputs reflect a sample one cycle after the edge that accepts it.
- Minimum time to lock: CONFIRM+1 accepted samples.
- `reversao` is high for exactly the one cycle after the reversing sample.
- Back-to-back valid samples are accepted every cycle; there is no backpressure.

## Structure
- Package `detector_pkg`:
  - `typedef enum` for states: VAZIO, BUSCA, TRAVADO, ERRO.
  - `typedef enum` for step classes: SUBIR, DESCER, PARADO, SALTO.
  - Constant `PASSOS_MAX` = 255.
- Sub-module `classificador_passo`: combinational; maps (`anterior`, `amostra`) to a step class; parameterised by NBITS_COUNT.
- Top level: FSM, registers, saturating counter.

## Test plan
- Reset, then samples 3,4,5,6 → `travado`=1 and `direcao`=1 one cycle after sample 5; `passos`=1 after sample 6.
- Samples 14,15,0,1 (N=4) → lock up through the wrap; `passos`=1 after 1. Then samples 1,0,15,14 → `reversao` pulses on the first 0, and the bench relocks with `direcao`=0 after 15.
- Locked up at 7, then sample 10 → `erro`=1 and `travado`=0. Further samples 11,12 leave `erro`=1. Then `limpar`=1 with a simultaneous valid → VAZIO, `erro`=0, sample discarded.
- Locked up, then hold 5 for 300 cycles with valid → no change. Then 260 up steps → `passos` saturates at 255.
- Samples 2,3,5,6,7 in BUSCA → the jump 3→5 resets `run` and sets no error; lock occurs after 7.
- `reset`=0 asserted asynchronously mid-lock between edges → outputs zero immediately. After release, the first sample goes only to BUSCA.
